// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory request/response port between the fetch stage and imem.
//   req    fetch request valid (master -> slave)
//   addr   fetch address, held while req=1 and not accepted (master -> slave)
//   ready  request accepted when req & ready (slave -> master)
//   rvalid response valid, one per accepted request (slave -> master)
//   rdata  instruction data qualified by rvalid (slave -> master)
//   err    access fault qualified by rvalid (slave -> master)
interface if_fetch_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic            rvalid;
    logic [ILEN-1:0] rdata;
    logic            err;

    modport master (output req, addr, input ready, rvalid, rdata, err);
    modport slave  (input req, addr, output ready, rvalid, rdata, err);
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage owning the PC, single-outstanding imem fetch, IF/ID slot.
//   clk, rst         clock, synchronous active-high reset
//   i_stall          ctrl stall vector; bit 1 holds the IF/ID slot
//   i_branch_flag    one-cycle redirect pulse
//   i_branch_target  redirect address
//   imem             instruction-memory port (master side)
//   o_if_pc          PC of the presented instruction
//   o_if_inst        presented instruction, 0 when no slot is valid
//   o_if_fault       presented slot is an access fault
//   o_stallreq_if    fetch not yet available (REQ or WAIT)
module if_fetch #(
    parameter int               XLEN     = 64,
    parameter int               ILEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      i_stall,
    input  logic            i_branch_flag,
    input  logic [XLEN-1:0] i_branch_target,
    if_fetch_if.master      imem,
    output logic [XLEN-1:0] o_if_pc,
    output logic [ILEN-1:0] o_if_inst,
    output logic            o_if_fault,
    output logic            o_stallreq_if
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_VALID = 2'd3;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_kill;
    logic            r_req;
    logic [XLEN-1:0] r_addr;
    logic [1:0]      w_state_n;
    logic [XLEN-1:0] w_pc_n;
    logic            w_kill_n;
    logic            w_load;
    logic            w_drop;
    logic            w_unused_stall;

    assign w_unused_stall = ^{i_stall[5:2], i_stall[0]};
    assign imem.req  = r_req;
    assign imem.addr = r_addr;

    // r_kill marks the in-flight (or about-to-be-issued) request as stale after a redirect,
    // so its response is swallowed and fetch resumes from the redirected pc.
    always_comb begin
        w_state_n = r_state;
        w_kill_n  = r_kill;
        w_load    = 1'b0;
        w_drop    = 1'b0;
        case (r_state)
            S_IDLE: w_state_n = S_REQ;
            S_REQ: begin
                if (i_branch_flag) w_kill_n = 1'b1;
                if (imem.ready) w_state_n = S_WAIT;
            end
            S_WAIT: begin
                if (imem.rvalid) begin
                    w_state_n = (r_kill || i_branch_flag) ? S_REQ : S_VALID;
                    w_load    = !(r_kill || i_branch_flag);
                    w_kill_n  = 1'b0;
                end else if (i_branch_flag) begin
                    w_kill_n = 1'b1;
                end
            end
            default: begin
                if (i_branch_flag || !i_stall[1]) begin
                    w_state_n = S_REQ;
                    w_drop    = 1'b1;
                end
            end
        endcase
        w_pc_n = i_branch_flag ? i_branch_target : w_load ? r_pc + XLEN'(4) : r_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_req         <= 1'b0;
            r_addr        <= RESET_PC;
            o_if_pc       <= '0;
            o_if_inst     <= '0;
            o_if_fault    <= 1'b0;
            o_stallreq_if <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_pc          <= w_pc_n;
            r_kill        <= w_kill_n;
            r_req         <= w_state_n == S_REQ;
            o_stallreq_if <= w_state_n == S_REQ || w_state_n == S_WAIT;
            // address is latched only on entry to REQ so it stays stable until accepted
            if (w_state_n == S_REQ && r_state != S_REQ) r_addr <= w_pc_n;
            if (w_load) begin
                o_if_pc    <= r_pc;
                o_if_inst  <= imem.err ? '0 : imem.rdata;
                o_if_fault <= imem.err;
            end else if (w_drop) begin
                o_if_inst  <= '0;
                o_if_fault <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios plus randomized imem/stall/branch traffic against a PC-stream model.
module tb_if_fetch;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch;
    logic [63:0] target;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fault;
    logic        stallreq;
    int          total = 0;
    int          bad = 0;

    if_fetch_if bus();

    if_fetch dut (
        .clk(clk),
        .rst(rst),
        .i_stall(stall),
        .i_branch_flag(branch),
        .i_branch_target(target),
        .imem(bus),
        .o_if_pc(if_pc),
        .o_if_inst(if_inst),
        .o_if_fault(if_fault),
        .o_stallreq_if(stallreq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    function automatic logic [162:0] pack(input logic req, input logic [63:0] addr, input logic [63:0] pc,
                                          input logic [31:0] inst, input logic fault, input logic sr);
        return {req, addr, pc, inst, fault, sr};
    endfunction

    function automatic logic [162:0] obs();
        return {bus.req, bus.addr, if_pc, if_inst, if_fault, stallreq};
    endfunction

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return (a[31:0] ^ 32'h1357_9bdf) | 32'h1;
    endfunction

    function automatic logic mem_err(input logic [63:0] a);
        return a[6:2] == 5'd9;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ready  = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        bus.err    = 1'b0;
        branch     = 1'b0;
        target     = '0;
        stall      = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        total++;
        if (obs() !== pack(0, RST_PC, 0, 0, 0, 0)) begin bad++; $display("FAIL reset: got %h want %h", obs(), pack(0, RST_PC, 0, 0, 0, 0)); end
    endtask

    task automatic test_basic();
        rst = 1'b0;
        bus.ready = 1'b1;
        step();
        total++;
        if (obs() !== pack(1, RST_PC, 0, 0, 0, 1)) begin bad++; $display("FAIL basic_req: got %h want %h", obs(), pack(1, RST_PC, 0, 0, 0, 1)); end
        step();
        total++;
        if (obs() !== pack(0, RST_PC, 0, 0, 0, 1)) begin bad++; $display("FAIL basic_wait: got %h want %h", obs(), pack(0, RST_PC, 0, 0, 0, 1)); end
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0000_0013;
        step();
        bus.rvalid = 1'b0;
        total++;
        if (obs() !== pack(0, RST_PC, RST_PC, 32'h13, 0, 0)) begin bad++; $display("FAIL basic_slot: got %h want %h", obs(), pack(0, RST_PC, RST_PC, 32'h13, 0, 0)); end
        step();
        total++;
        if (obs() !== pack(1, RST_PC + 4, RST_PC, 0, 0, 1)) begin bad++; $display("FAIL basic_next: got %h want %h", obs(), pack(1, RST_PC + 4, RST_PC, 0, 0, 1)); end
    endtask

    task automatic test_stall_hold();
        bus.ready = 1'b1;
        step();
        bus.ready  = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0010_0093;
        stall      = 6'b000010;
        step();
        bus.rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (obs() !== pack(0, RST_PC + 4, RST_PC + 4, 32'h0010_0093, 0, 0)) begin bad++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs(), pack(0, RST_PC + 4, RST_PC + 4, 32'h0010_0093, 0, 0)); end
        end
        stall = '0;
        step();
        total++;
        if (obs() !== pack(1, RST_PC + 8, RST_PC + 4, 0, 0, 1)) begin bad++; $display("FAIL stall_release: got %h want %h", obs(), pack(1, RST_PC + 8, RST_PC + 4, 0, 0, 1)); end
    endtask

    task automatic test_branch_wait();
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        branch    = 1'b1;
        target    = 64'h0000_0000_8000_0100;
        step();
        branch = 1'b0;
        total++;
        if (obs() !== pack(0, RST_PC + 8, RST_PC + 4, 0, 0, 1)) begin bad++; $display("FAIL branch_wait_kill: got %h want %h", obs(), pack(0, RST_PC + 8, RST_PC + 4, 0, 0, 1)); end
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hdead_beef;
        step();
        bus.rvalid = 1'b0;
        total++;
        if (obs() !== pack(1, 64'h8000_0100, RST_PC + 4, 0, 0, 1)) begin bad++; $display("FAIL branch_wait_drop: got %h want %h", obs(), pack(1, 64'h8000_0100, RST_PC + 4, 0, 0, 1)); end
    endtask

    task automatic test_branch_rvalid();
        bus.ready = 1'b1;
        step();
        bus.ready  = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hcafe_f00d;
        branch     = 1'b1;
        target     = 64'h0000_0000_8000_0200;
        step();
        bus.rvalid = 1'b0;
        branch     = 1'b0;
        total++;
        if (obs() !== pack(1, 64'h8000_0200, RST_PC + 4, 0, 0, 1)) begin bad++; $display("FAIL branch_rvalid: got %h want %h", obs(), pack(1, 64'h8000_0200, RST_PC + 4, 0, 0, 1)); end
        bus.ready = 1'b1;
        step();
        bus.ready  = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h55;
        step();
        bus.rvalid = 1'b0;
        total++;
        if (obs() !== pack(0, 64'h8000_0200, 64'h8000_0200, 32'h55, 0, 0)) begin bad++; $display("FAIL branch_target_fetch: got %h want %h", obs(), pack(0, 64'h8000_0200, 64'h8000_0200, 32'h55, 0, 0)); end
    endtask

    task automatic test_ready_low();
        step();
        total++;
        if (obs() !== pack(1, 64'h8000_0204, 64'h8000_0200, 0, 0, 1)) begin bad++; $display("FAIL consume_next: got %h want %h", obs(), pack(1, 64'h8000_0204, 64'h8000_0200, 0, 0, 1)); end
        for (int i = 0; i < 5; i++) begin
            branch = i == 2;
            target = 64'h0000_0000_8000_0300;
            step();
            branch = 1'b0;
            total++;
            if (obs() !== pack(1, 64'h8000_0204, 64'h8000_0200, 0, 0, 1)) begin bad++; $display("FAIL ready_low[%0d]: got %h want %h", i, obs(), pack(1, 64'h8000_0204, 64'h8000_0200, 0, 0, 1)); end
        end
        bus.ready = 1'b1;
        step();
        bus.ready  = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h99;
        step();
        bus.rvalid = 1'b0;
        total++;
        if (obs() !== pack(1, 64'h8000_0300, 64'h8000_0200, 0, 0, 1)) begin bad++; $display("FAIL stable_branch_drop: got %h want %h", obs(), pack(1, 64'h8000_0300, 64'h8000_0200, 0, 0, 1)); end
    endtask

    task automatic test_fault_reset();
        bus.ready = 1'b1;
        step();
        bus.ready  = 1'b0;
        bus.rvalid = 1'b1;
        bus.err    = 1'b1;
        bus.rdata  = 32'hffff_ffff;
        step();
        bus.rvalid = 1'b0;
        bus.err    = 1'b0;
        total++;
        if (obs() !== pack(0, 64'h8000_0300, 64'h8000_0300, 0, 1, 0)) begin bad++; $display("FAIL fault_slot: got %h want %h", obs(), pack(0, 64'h8000_0300, 64'h8000_0300, 0, 1, 0)); end
        step();
        total++;
        if (obs() !== pack(1, 64'h8000_0304, 64'h8000_0300, 0, 0, 1)) begin bad++; $display("FAIL fault_clear: got %h want %h", obs(), pack(1, 64'h8000_0304, 64'h8000_0300, 0, 0, 1)); end
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        rst = 1'b1;
        step();
        total++;
        if (obs() !== pack(0, RST_PC, 0, 0, 0, 0)) begin bad++; $display("FAIL reset_mid: got %h want %h", obs(), pack(0, RST_PC, 0, 0, 0, 0)); end
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1234;
        step();
        rst = 1'b0;
        step();
        bus.rvalid = 1'b0;
        total++;
        if (obs() !== pack(1, RST_PC, 0, 0, 0, 1)) begin bad++; $display("FAIL late_rvalid_ignored: got %h want %h", obs(), pack(1, RST_PC, 0, 0, 0, 1)); end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        clear_inputs();
        step();
        rst    = 1'b0;
        branch = 1'b1;
        target = 64'hffff_ffff_ffff_fffc;
        step();
        branch = 1'b0;
        total++;
        if (obs() !== pack(1, 64'hffff_ffff_ffff_fffc, 0, 0, 0, 1)) begin bad++; $display("FAIL idle_branch: got %h want %h", obs(), pack(1, 64'hffff_ffff_ffff_fffc, 0, 0, 0, 1)); end
        bus.ready = 1'b1;
        step();
        bus.ready  = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h77;
        step();
        bus.rvalid = 1'b0;
        total++;
        if (obs() !== pack(0, 64'hffff_ffff_ffff_fffc, 64'hffff_ffff_ffff_fffc, 32'h77, 0, 0)) begin bad++; $display("FAIL wrap_slot: got %h want %h", obs(), pack(0, 64'hffff_ffff_ffff_fffc, 64'hffff_ffff_ffff_fffc, 32'h77, 0, 0)); end
        step();
        total++;
        if (obs() !== pack(1, 64'h0, 64'hffff_ffff_ffff_fffc, 0, 0, 1)) begin bad++; $display("FAIL wrap_next: got %h want %h", obs(), pack(1, 64'h0, 64'hffff_ffff_ffff_fffc, 0, 0, 1)); end
    endtask

    // Model: the stream of consumed slots follows pc, pc+4, ... restarting at each branch target;
    // memory contents and faults are fixed functions of the address.
    task automatic test_random();
        logic [63:0] exp_pc, paddr, prev_addr;
        logic        pending, prev_hold, present, rv;
        int          dly, consumed;
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst       = 1'b0;
        exp_pc    = RST_PC;
        pending   = 1'b0;
        prev_hold = 1'b0;
        prev_addr = '0;
        paddr     = '0;
        dly       = 0;
        consumed  = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (prev_hold) begin
                total++;
                if ({bus.req, bus.addr} !== {1'b1, prev_addr}) begin bad++; $display("FAIL addr_stable@%0d: got req=%b addr=%h want req=1 addr=%h", c, bus.req, bus.addr, prev_addr); end
            end
            if (bus.req) begin
                total++;
                if (pending) begin bad++; $display("FAIL single_outstanding@%0d: got req with response pending, want no req", c); end
            end
            present    = !bus.req && !stallreq && (if_inst != 0 || if_fault);
            rv         = pending && dly == 0;
            bus.rvalid = rv;
            bus.rdata  = rv ? mem_data(paddr) : $urandom;
            bus.err    = rv ? mem_err(paddr) : 1'($urandom % 2);
            if (rv) pending = 1'b0;
            else if (pending) dly--;
            bus.ready = 1'($urandom % 2);
            branch    = $urandom % 20 == 0;
            target    = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0ffc)};
            stall     = 6'($urandom);
            if (bus.req && bus.ready) begin
                pending = 1'b1;
                paddr   = bus.addr;
                dly     = $urandom % 3;
            end
            prev_hold = bus.req && !bus.ready;
            prev_addr = bus.addr;
            if (branch) exp_pc = target;
            else if (present && !stall[1]) begin
                total++;
                if ({if_pc, if_inst, if_fault} !== {exp_pc, mem_err(exp_pc) ? 32'h0 : mem_data(exp_pc), mem_err(exp_pc)}) begin
                    bad++;
                    $display("FAIL slot@%0d: got pc=%h inst=%h fault=%b want pc=%h inst=%h fault=%b", c, if_pc, if_inst, if_fault,
                             exp_pc, mem_err(exp_pc) ? 32'h0 : mem_data(exp_pc), mem_err(exp_pc));
                end
                exp_pc = exp_pc + 64'd4;
                consumed++;
            end
        end
        @(negedge clk);
        clear_inputs();
        total++;
        if (consumed < 100) begin bad++; $display("FAIL progress: got %0d slots consumed, want at least 100", consumed); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_hold();
        test_branch_wait();
        test_branch_rvalid();
        test_ready_low();
        test_fault_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
